// File: rtl/tx_word_unfold_ctrl_if.sv
// AXI-Stream word port feeding the bit-unfold controller.
// The master drives data/valid/last; the slave returns ready.
interface tx_word_unfold_ctrl_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/tx_word_unfold_ctrl.sv
// Control stage ahead of the 32-entry bit-unfold RAM: latches a word, sweeps the RAM address MSB
// first with each bit held SPS clocks, and flags valid samples. Optional macro: TX_UNFOLD_TLAST_EN.
module tx_word_unfold_ctrl #(
   parameter int SPS    = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   tx_word_unfold_ctrl_if.slave s_axis,
   output logic [DATA_W-1:0]  ram_data,
   output logic               ram_ena,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic               bit_valid,
   output logic               frame_start,
   output logic               frame_end,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   localparam logic [7:0]        SPS_LAST  = 8'(SPS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ram_data_q, ram_data_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        sps_cnt_q, sps_cnt_d;
   logic              ram_ena_q, ram_ena_d;
   logic              ready_slot_q, ready_slot_d;
   logic              bit_valid_q, bit_valid_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_end_q, frame_end_d;
   logic              busy_q, busy_d;

   logic accept;
   logic in_shift;
   logic terminal;
   logic word_first;
   logic word_last;

   // ready_slot_q marks the cycles that may take a word (IDLE or the SHIFT terminal cycle);
   // enable gates it combinationally so dropping enable blocks the lookahead in the same cycle.
   assign s_axis.tready = ready_slot_q & enable;
   assign accept        = s_axis.tvalid & s_axis.tready;
   assign in_shift      = (state_q == S_SHIFT);
   assign terminal      = in_shift && (ram_addr_q == ADDR_LAST) && (sps_cnt_q == SPS_LAST);

`ifdef TX_UNFOLD_TLAST_EN
   logic word_first_q, word_first_d;
   logic word_last_q, word_last_d;
   logic frame_open_q, frame_open_d;

   always_comb begin
      word_first_d = word_first_q;
      word_last_d  = word_last_q;
      frame_open_d = frame_open_q;
      if (accept) begin
         word_first_d = ~frame_open_q;
         word_last_d  = s_axis.tlast;
         frame_open_d = ~s_axis.tlast;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_first_q <= 1'b0;
         word_last_q  <= 1'b0;
         frame_open_q <= 1'b0;
      end else begin
         word_first_q <= word_first_d;
         word_last_q  <= word_last_d;
         frame_open_q <= frame_open_d;
      end
   end

   assign word_first = word_first_q;
   assign word_last  = word_last_q;
`else
   logic unused_tlast;

   assign unused_tlast = s_axis.tlast;
   assign word_first   = 1'b1;
   assign word_last    = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      ram_data_d = ram_data_q;
      ram_addr_d = ram_addr_q;
      sps_cnt_d  = sps_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ram_data_d = s_axis.tdata;
               ram_addr_d = '0;
               sps_cnt_d  = '0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            ram_addr_d = '0;
            sps_cnt_d  = '0;
            state_d    = S_SHIFT;
         end
         S_SHIFT: begin
            if (sps_cnt_q == SPS_LAST) begin
               sps_cnt_d  = '0;
               ram_addr_d = ram_addr_q + ADDR_W'(1);
            end else begin
               sps_cnt_d  = sps_cnt_q + 8'd1;
            end
            if (terminal) begin
               ram_addr_d = '0;
               if (accept) begin
                  ram_data_d = s_axis.tdata;
                  state_d    = S_LOAD;
               end else begin
                  state_d    = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ram_ena_d     = (state_d != S_IDLE);
      ready_slot_d  = (state_d == S_IDLE) ||
                      ((state_d == S_SHIFT) && (ram_addr_d == ADDR_LAST) && (sps_cnt_d == SPS_LAST));
      // Marker/valid flops sit one cycle behind SHIFT, matching the RAM's registered read.
      bit_valid_d   = in_shift;
      frame_start_d = in_shift && (ram_addr_q == '0) && (sps_cnt_q == '0) && word_first;
      frame_end_d   = terminal && word_last;
      busy_d        = (state_d != S_IDLE) || bit_valid_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         ram_data_q    <= '0;
         ram_addr_q    <= '0;
         sps_cnt_q     <= '0;
         ram_ena_q     <= 1'b0;
         ready_slot_q  <= 1'b0;
         bit_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ram_data_q    <= ram_data_d;
         ram_addr_q    <= ram_addr_d;
         sps_cnt_q     <= sps_cnt_d;
         ram_ena_q     <= ram_ena_d;
         ready_slot_q  <= ready_slot_d;
         bit_valid_q   <= bit_valid_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
         busy_q        <= busy_d;
      end
   end

   assign ram_data    = ram_data_q;
   assign ram_ena     = ram_ena_q;
   assign ram_addr    = ram_addr_q;
   assign bit_valid   = bit_valid_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_tx_word_unfold_ctrl.sv
// Bench for tx_word_unfold_ctrl: an SPS=4 instance checked against a word scoreboard through a
// RAM model, plus an SPS=1 instance for the single-clock-per-bit sweep.
`timescale 1ns/1ps
module tb_tx_word_unfold_ctrl;

   localparam int SPS4         = 4;
   localparam int SPS1         = 1;
   localparam int WORD_SAMPLES = 32 * SPS4;

   typedef struct packed {
      logic [31:0] word;
      logic        first;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   logic enable4;
   logic enable1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tx_word_unfold_ctrl_if ax4 ();
   tx_word_unfold_ctrl_if ax1 ();

   logic [31:0] ram_data4, ram_data1;
   logic        ram_ena4, ram_ena1;
   logic [4:0]  ram_addr4, ram_addr1;
   logic        bv4, fs4, fe4, busy4;
   logic        bv1, fs1, fe1, busy1;
   logic        rd4, rd1;

   tx_word_unfold_ctrl #(.SPS(SPS4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .enable(enable4), .s_axis(ax4),
      .ram_data(ram_data4), .ram_ena(ram_ena4), .ram_addr(ram_addr4),
      .bit_valid(bv4), .frame_start(fs4), .frame_end(fe4), .busy(busy4)
   );

   tx_word_unfold_ctrl #(.SPS(SPS1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .enable(enable1), .s_axis(ax1),
      .ram_data(ram_data1), .ram_ena(ram_ena1), .ram_addr(ram_addr1),
      .bit_valid(bv1), .frame_start(fs1), .frame_end(fe1), .busy(busy1)
   );

   // Behavioural RAM: address 0 holds the word MSB, read is registered.
   always @(posedge clk) begin
      if (ram_ena4) rd4 <= ram_data4[5'd31 - ram_addr4];
      if (ram_ena1) rd1 <= ram_data1[5'd31 - ram_addr1];
      cyc <= cyc + 1;
   end

   int xfer_cnt = 0;
   always @(posedge clk) begin
      if (reset_n && ax4.tvalid && ax4.tready) xfer_cnt <= xfer_cnt + 1;
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   exp_t        exp_q[$];
   exp_t        cur;
   logic        exp_open = 1'b0;
   int          samp_cnt = 0;
   logic [31:0] acc4;
   logic        marks_ok = 1'b1;
   int          bv_total = 0;
   int          fs_cnt = 0;
   int          fe_cnt = 0;

   // Scoreboard: rebuild each word from the RAM model on bit_valid and compare with the queue.
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         samp_cnt = 0;
         marks_ok = 1'b1;
      end else begin
         if (fs4 === 1'b1) fs_cnt++;
         if (fe4 === 1'b1) fe_cnt++;
         if (bv4 === 1'b1) begin
            bv_total++;
            if (samp_cnt == 0) begin
               check_output("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) cur = exp_q.pop_front();
               else cur = '0;
               acc4 = '0;
            end
            if (samp_cnt % SPS4 == 0) acc4 = {acc4[30:0], rd4};
            else if (rd4 !== acc4[0]) marks_ok = 1'b0;
            if (fs4 !== ((samp_cnt == 0) && cur.first)) marks_ok = 1'b0;
            if (fe4 !== ((samp_cnt == WORD_SAMPLES - 1) && cur.last)) marks_ok = 1'b0;
            samp_cnt++;
            if (samp_cnt == WORD_SAMPLES) begin
               check_output("sb_word", acc4, cur.word);
               check_output("sb_markers", 32'(marks_ok), 32'd1);
               samp_cnt = 0;
               marks_ok = 1'b1;
            end
         end else if (samp_cnt != 0 || fs4 !== 1'b0 || fe4 !== 1'b0) begin
            marks_ok = 1'b0;
         end
      end
   end

   // Offers one word to the SPS=4 instance; returns at the negedge after it is taken.
   task automatic apply_stimulus(input logic [31:0] w, input logic last, output int acc_cyc);
      logic got;
      exp_t e;
      got = 1'b0;
      acc_cyc = 0;
      ax4.tdata  = w;
      ax4.tlast  = last;
      ax4.tvalid = 1'b1;
      for (int i = 0; i < 400 && !got; i++) begin
         #1;
         if (ax4.tready === 1'b1) begin
            got = 1'b1;
            e.word = w;
`ifdef TX_UNFOLD_TLAST_EN
            e.first  = ~exp_open;
            e.last   = last;
            exp_open = ~last;
`else
            e.first = 1'b1;
            e.last  = 1'b1;
`endif
            exp_q.push_back(e);
         end
         @(posedge clk);
         @(negedge clk);
      end
      acc_cyc = cyc;
      check_output("accept_in_budget", 32'(got), 32'd1);
   endtask

   task automatic wait_idle4(input string tag);
      int n;
      n = 0;
      while (busy4 !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_output(tag, 32'(busy4), 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          cyc_a, cyc_b, cyc_x;
      int          addr_err, first_bv, bv1_cnt, max_addr, x0, b0;
      logic [31:0] acc1;
      logic [2:0]  gap;
      logic        rdy_seen, prev_bv, prev_busy, done, ena_ok;

      reset_n    = 1'b0;
      enable4    = 1'b1;
      enable1    = 1'b0;
      ax4.tvalid = 1'b0; ax4.tdata = '0; ax4.tlast = 1'b0;
      ax1.tvalid = 1'b0; ax1.tdata = '0; ax1.tlast = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      check_output("rst_tready", 32'(ax4.tready), 32'd0);
      check_output("rst_ram_data", ram_data4, 32'd0);
      check_output("rst_ram_ena", 32'(ram_ena4), 32'd0);
      check_output("rst_ram_addr", 32'(ram_addr4), 32'd0);
      check_output("rst_flags", 32'({bv4, fs4, fe4, busy4}), 32'd0);
      check_output("rst_busy1", 32'(busy1), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // SPS=1 sweep of a single word.
      enable1    = 1'b1;
      ax1.tdata  = 32'hA5A5_0001;
      ax1.tvalid = 1'b1;
      #1;
      check_output("t1_tready_idle", 32'(ax1.tready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      ax1.tvalid = 1'b0;
      #1;
      check_output("t1_tready_drop", 32'(ax1.tready), 32'd0);
      ena_ok = ram_ena1;
      addr_err = 0; first_bv = -1; bv1_cnt = 0; acc1 = '0;
      for (int j = 0; j < 36; j++) begin
         if (j >= 1 && j <= 32 && ram_addr1 !== 5'(j - 1)) addr_err++;
         if (bv1 === 1'b1) begin
            if (first_bv < 0) first_bv = j;
            bv1_cnt++;
            acc1 = {acc1[30:0], rd1};
         end
         @(negedge clk);
      end
      check_output("t1_load_ena", 32'(ena_ok), 32'd1);
      check_output("t1_addr_sweep_errs", 32'(addr_err), 32'd0);
      check_output("t1_bv_count", 32'(bv1_cnt), 32'd32);
      check_output("t1_bv_first", 32'(first_bv), 32'd2);
      check_output("t1_bits", acc1, 32'hA5A5_0001);
      check_output("t1_ram_data", ram_data1, 32'hA5A5_0001);
      check_output("t1_idle", 32'({ram_ena1, busy1}), 32'd0);

      // SPS=4 back-to-back words.
      apply_stimulus(32'hDEAD_BEEF, 1'b0, cyc_a);
      apply_stimulus(32'h0123_4567, 1'b1, cyc_b);
      ax4.tvalid = 1'b0;
      check_output("t2_accept_spacing", 32'(cyc_b - cyc_a), 32'(1 + WORD_SAMPLES));
      gap = '0; addr_err = 0;
      for (int j = 0; j < 13; j++) begin
         if (j < 3) gap = {gap[1:0], bv4};
         if (j >= 1 && ram_addr4 !== 5'((j - 1) / SPS4)) addr_err++;
         @(negedge clk);
      end
      check_output("t2_bv_gap", 32'(gap), 32'b101);
      check_output("t2_addr_hold_errs", 32'(addr_err), 32'd0);
      wait_idle4("t2_idle");

      // enable dropped mid-word.
      apply_stimulus(32'hF0F0_1234, 1'b1, cyc_x);
      ax4.tvalid = 1'b0;
      for (int i = 0; i < 200 && ram_addr4 !== 5'd10; i++) @(negedge clk);
      check_output("t3_reach_addr10", 32'(ram_addr4), 32'd10);
      enable4    = 1'b0;
      ax4.tdata  = 32'h5555_AAAA;
      ax4.tvalid = 1'b1;
      max_addr = 0; rdy_seen = 1'b0; prev_bv = 1'b0; prev_busy = 1'b0; done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         #1;
         if (ax4.tready !== 1'b0) rdy_seen = 1'b1;
         if (int'(ram_addr4) > max_addr) max_addr = int'(ram_addr4);
         if (prev_bv && bv4 === 1'b0) done = 1'b1;
         else begin
            prev_bv   = bv4;
            prev_busy = busy4;
            @(negedge clk);
         end
      end
      check_output("t3_finished", 32'(done), 32'd1);
      check_output("t3_tready_blocked", 32'(rdy_seen), 32'd0);
      check_output("t3_max_addr", 32'(max_addr), 32'd31);
      check_output("t3_busy_at_last_bv", 32'(prev_busy), 32'd1);
      check_output("t3_busy_after", 32'(busy4), 32'd0);
      check_output("t3_ram_ena_off", 32'(ram_ena4), 32'd0);
      ax4.tvalid = 1'b0;
      enable4    = 1'b1;
      @(negedge clk);

      // Reset in the middle of a word.
      apply_stimulus(32'h1234_5678, 1'b1, cyc_x);
      ax4.tvalid = 1'b0;
      for (int i = 0; i < 200 && ram_addr4 !== 5'd17; i++) @(negedge clk);
      check_output("t4_reach_addr17", 32'(ram_addr4), 32'd17);
      reset_n = 1'b0;
      #1;
      check_output("t4_rst_tready", 32'(ax4.tready), 32'd0);
      check_output("t4_rst_ram_data", ram_data4, 32'd0);
      check_output("t4_rst_ram_ena", 32'(ram_ena4), 32'd0);
      check_output("t4_rst_ram_addr", 32'(ram_addr4), 32'd0);
      check_output("t4_rst_flags", 32'({bv4, fs4, fe4, busy4}), 32'd0);
      repeat (2) @(negedge clk);
      reset_n  = 1'b1;
      exp_open = 1'b0;
      @(negedge clk);
      apply_stimulus(32'hFFFF_FFFF, 1'b1, cyc_x);
      ax4.tvalid = 1'b0;
      addr_err = 0;
      for (int j = 0; j < 9; j++) begin
         if (j >= 1 && ram_addr4 !== 5'((j - 1) / SPS4)) addr_err++;
         if (j == 0 && (ram_addr4 !== 5'd0 || ram_ena4 !== 1'b1)) addr_err++;
         @(negedge clk);
      end
      check_output("t4_sweep_from_zero_errs", 32'(addr_err), 32'd0);
      wait_idle4("t4_idle");

      // Three-word frame, tlast on the third word.
      fs_cnt = 0;
      fe_cnt = 0;
      apply_stimulus(32'h0000_00FF, 1'b0, cyc_x);
      apply_stimulus(32'h8000_0000, 1'b0, cyc_x);
      apply_stimulus(32'h3C3C_C3C3, 1'b1, cyc_x);
      ax4.tvalid = 1'b0;
      wait_idle4("t5_idle");
`ifdef TX_UNFOLD_TLAST_EN
      check_output("t5_frame_start_cnt", 32'(fs_cnt), 32'd1);
      check_output("t5_frame_end_cnt", 32'(fe_cnt), 32'd1);
`else
      check_output("t5_frame_start_cnt", 32'(fs_cnt), 32'd3);
      check_output("t5_frame_end_cnt", 32'(fe_cnt), 32'd3);
`endif

      // tvalid held high across four words.
      @(negedge clk);
      x0 = xfer_cnt;
      b0 = bv_total;
      apply_stimulus(32'h1111_2222, 1'b0, cyc_x);
      apply_stimulus(32'h3333_4444, 1'b0, cyc_x);
      apply_stimulus(32'h5555_6666, 1'b0, cyc_x);
      apply_stimulus(32'h7777_8888, 1'b1, cyc_x);
      ax4.tvalid = 1'b0;
      wait_idle4("t6_idle");
      repeat (2) @(negedge clk);
      check_output("t6_transfers", 32'(xfer_cnt - x0), 32'd4);
      check_output("t6_bv_total", 32'(bv_total - b0), 32'(4 * WORD_SAMPLES));
      check_output("sb_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
